mem_arbiter: RTL and testbench

Sits directly downstream of the cache block and owns the single RAM port. It arbitrates between instruction-cache and data-cache requests and drives RAM read/write strobes, address and store data. It returns load data and per-side wait signals to the caches. Registered grant FSM: one requester owns the bus until the RAM reports ACCESS or the request is withdrawn.

---
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the single RAM port and grants it to either the data
// cache or the instruction cache. Data has priority. A grant is held until the
// RAM reports ACCESS, the requester withdraws, or MAX_RETRY ERROR cycles are
// seen. Every transaction ends with one TURN cycle that drives no strobes.
// Optional feature macro: MEM_ARB_RR_EN. When it is defined, a fairness bit
// hands the next grant to the instruction side after a data completion if both
// sides are requesting.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_RETRY = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              arb_err
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DSERV = 2'd1,
    ST_ISERV = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [RW-1:0] r_retry;
  logic [RW-1:0] w_retry_inc;
  logic          w_dreq;
  logic          w_access;
  logic          w_serv_err;
  logic          w_exhaust;
  logic          w_ddone;
  logic          w_idone;
  logic          w_serv_next;

  assign w_dreq      = dREN | dWEN;
  assign w_access    = (ramstate == RS_ACCESS);
  assign w_retry_inc = r_retry + RW'(1);
  // An ERROR only counts while the granted side is still asking for the bus.
  assign w_serv_err  = (ramstate == RS_ERROR) &&
                       (((r_state == ST_DSERV) && w_dreq) ||
                        ((r_state == ST_ISERV) && iREN));
  assign w_exhaust   = w_serv_err && (w_retry_inc == RETRY_LIM);
  assign w_ddone     = (r_state == ST_DSERV) && w_dreq && w_access;
  assign w_idone     = (r_state == ST_ISERV) && iREN && w_access;
  assign w_serv_next = (w_next == ST_DSERV) || (w_next == ST_ISERV);

  // Load data is a straight passthrough; the wait signals qualify it.
  assign iload = ramload;
  assign dload = ramload;

`ifdef MEM_ARB_RR_EN
  logic r_fair;

  // Fairness bit: set by a data completion, cleared by an instruction completion.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fair <= 1'b0;
    end else if (w_ddone) begin
      r_fair <= 1'b1;
    end else if (w_idone) begin
      r_fair <= 1'b0;
    end else begin
      r_fair <= r_fair;
    end
  end
`endif

  // Grant state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Retry counter: counts ERROR cycles within one grant and clears when the grant ends.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_retry <= '0;
    end else if (!w_serv_next) begin
      r_retry <= '0;
    end else if (w_serv_err) begin
      r_retry <= w_retry_inc;
    end else begin
      r_retry <= r_retry;
    end
  end

  // Next-state logic: withdrawal is checked before completion or retry exhaustion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
`ifdef MEM_ARB_RR_EN
        if (w_dreq && !(iREN && r_fair)) begin
          w_next = ST_DSERV;
        end else if (iREN) begin
          w_next = ST_ISERV;
        end else begin
          w_next = ST_IDLE;
        end
`else
        if (w_dreq) begin
          w_next = ST_DSERV;
        end else if (iREN) begin
          w_next = ST_ISERV;
        end else begin
          w_next = ST_IDLE;
        end
`endif
      end
      ST_DSERV: begin
        if (!w_dreq) begin
          w_next = ST_IDLE;
        end else if (w_access || w_exhaust) begin
          w_next = ST_TURN;
        end else begin
          w_next = ST_DSERV;
        end
      end
      ST_ISERV: begin
        if (!iREN) begin
          w_next = ST_IDLE;
        end else if (w_access || w_exhaust) begin
          w_next = ST_TURN;
        end else begin
          w_next = ST_ISERV;
        end
      end
      ST_TURN: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Output logic: the RAM strobes follow the live requester inputs while that side holds the grant.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    arb_err  = 1'b0;
    case (r_state)
      ST_DSERV: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~w_ddone;
        arb_err  = w_exhaust;
      end
      ST_ISERV: begin
        ramREN   = iREN;
        ramaddr  = iaddr;
        iwait    = ~w_idone;
        arb_err  = w_exhaust;
      end
      default: begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. It drives inputs 1 ns after each rising
// edge and samples outputs 2 ns later. The ctl vector is
// {ramREN, ramWEN, iwait, dwait, arb_err}.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        arb_err;
  logic [4:0]  ctl;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  always #5 CLK = ~CLK;

  assign ctl = {ramREN, ramWEN, iwait, dwait, arb_err};

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h4; dREN = 1'b0; dWEN = 1'b1;
    daddr = 32'hFF; dstore = 32'hEE; ramstate = ACCESS; ramload = 32'h12345678;
    #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL rst_ctl: got %b want %b", ctl, 5'b00110); bad++; end
    total++; if (ramaddr !== 32'h0) begin $display("FAIL rst_addr: got %h want %h", ramaddr, 32'h0); bad++; end
    total++; if (ramstore !== 32'h0) begin $display("FAIL rst_store: got %h want %h", ramstore, 32'h0); bad++; end
    @(posedge CLK); #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL rst_hold_ctl: got %b want %b", ctl, 5'b00110); bad++; end
    total++; if (iload !== 32'h12345678) begin $display("FAIL rst_iload: got %h want %h", iload, 32'h12345678); bad++; end
    total++; if (dload !== 32'h12345678) begin $display("FAIL rst_dload: got %h want %h", dload, 32'h12345678); bad++; end
    iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    #1 nRST = 1'b1;
  endtask

  task automatic test_icache_read();
    cyc(); iREN = 1'b1; iaddr = 32'h40; ramstate = FREE; #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL ird_req: got %b want %b", ctl, 5'b00110); bad++; end
    cyc(); ramstate = BUSY; #2;
    total++; if (ctl !== 5'b10110) begin $display("FAIL ird_busy: got %b want %b", ctl, 5'b10110); bad++; end
    total++; if (ramaddr !== 32'h40) begin $display("FAIL ird_addr: got %h want %h", ramaddr, 32'h40); bad++; end
    cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #2;
    total++; if (ctl !== 5'b10010) begin $display("FAIL ird_access: got %b want %b", ctl, 5'b10010); bad++; end
    total++; if (iload !== 32'hDEADBEEF) begin $display("FAIL ird_iload: got %h want %h", iload, 32'hDEADBEEF); bad++; end
    cyc(); ramstate = FREE; #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL ird_turn: got %b want %b", ctl, 5'b00110); bad++; end
    iREN = 1'b0;
    cyc(); #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL ird_idle: got %b want %b", ctl, 5'b00110); bad++; end
  endtask

  task automatic test_priority();
    cyc(); iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234; ramstate = FREE; #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL pri_req: got %b want %b", ctl, 5'b00110); bad++; end
    cyc(); ramstate = ACCESS; #2;
    total++; if (ctl !== 5'b01100) begin $display("FAIL pri_dserv: got %b want %b", ctl, 5'b01100); bad++; end
    total++; if (ramaddr !== 32'h80) begin $display("FAIL pri_daddr: got %h want %h", ramaddr, 32'h80); bad++; end
    total++; if (ramstore !== 32'h1234) begin $display("FAIL pri_dstore: got %h want %h", ramstore, 32'h1234); bad++; end
    cyc(); dWEN = 1'b0; ramstate = FREE; #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL pri_turn: got %b want %b", ctl, 5'b00110); bad++; end
    cyc(); #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL pri_idle: got %b want %b", ctl, 5'b00110); bad++; end
    cyc(); ramstate = ACCESS; ramload = 32'h55; #2;
    total++; if (ctl !== 5'b10010) begin $display("FAIL pri_iserv: got %b want %b", ctl, 5'b10010); bad++; end
    total++; if (ramaddr !== 32'h44) begin $display("FAIL pri_iaddr: got %h want %h", ramaddr, 32'h44); bad++; end
    total++; if (ramstore !== 32'h0) begin $display("FAIL pri_istore: got %h want %h", ramstore, 32'h0); bad++; end
    cyc(); iREN = 1'b0; ramstate = FREE;
    cyc();
  endtask

  task automatic test_rw_both();
    cyc(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hA5A5; ramstate = FREE;
    cyc(); ramstate = BUSY; #2;
    total++; if (ctl !== 5'b01110) begin $display("FAIL rw_write_wins: got %b want %b", ctl, 5'b01110); bad++; end
    total++; if (ramstore !== 32'hA5A5) begin $display("FAIL rw_store: got %h want %h", ramstore, 32'hA5A5); bad++; end
    cyc(); dWEN = 1'b0; #2;
    total++; if (ctl !== 5'b10110) begin $display("FAIL rw_live_read: got %b want %b", ctl, 5'b10110); bad++; end
    cyc(); ramstate = ACCESS; ramload = 32'hCAFE; #2;
    total++; if (ctl !== 5'b10100) begin $display("FAIL rw_done: got %b want %b", ctl, 5'b10100); bad++; end
    total++; if (dload !== 32'hCAFE) begin $display("FAIL rw_dload: got %h want %h", dload, 32'hCAFE); bad++; end
    cyc(); dREN = 1'b0; ramstate = FREE;
    cyc();
  endtask

  task automatic test_withdraw();
    cyc(); iREN = 1'b1; iaddr = 32'h48; ramstate = FREE;
    cyc(); ramstate = BUSY; #2;
    total++; if (ctl !== 5'b10110) begin $display("FAIL wd_busy: got %b want %b", ctl, 5'b10110); bad++; end
    cyc(); iREN = 1'b0; #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL wd_drop: got %b want %b", ctl, 5'b00110); bad++; end
    cyc(); dWEN = 1'b1; daddr = 32'h90; dstore = 32'h1; #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL wd_idle: got %b want %b", ctl, 5'b00110); bad++; end
    cyc(); ramstate = ACCESS; #2;
    total++; if (ctl !== 5'b01100) begin $display("FAIL wd_regrant: got %b want %b", ctl, 5'b01100); bad++; end
    total++; if (ramaddr !== 32'h90) begin $display("FAIL wd_addr: got %h want %h", ramaddr, 32'h90); bad++; end
    cyc(); dWEN = 1'b0; ramstate = FREE;
    cyc();
  endtask

  task automatic test_error_exhaust();
    cyc(); dWEN = 1'b1; daddr = 32'hC0; dstore = 32'h5; ramstate = FREE;
    cyc(); ramstate = ERROR; #2;
    total++; if (ctl !== 5'b01110) begin $display("FAIL err_1: got %b want %b", ctl, 5'b01110); bad++; end
    cyc(); #2;
    total++; if (ctl !== 5'b01110) begin $display("FAIL err_2: got %b want %b", ctl, 5'b01110); bad++; end
    cyc(); #2;
    total++; if (ctl !== 5'b01111) begin $display("FAIL err_3: got %b want %b", ctl, 5'b01111); bad++; end
    cyc(); ramstate = ACCESS; #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL err_turn: got %b want %b", ctl, 5'b00110); bad++; end
    cyc(); dWEN = 1'b0; ramstate = FREE; #2;
    total++; if (ctl !== 5'b00110) begin $display("FAIL err_idle: got %b want %b", ctl, 5'b00110); bad++; end
  endtask

  task automatic test_error_recover();
    cyc(); iREN = 1'b1; iaddr = 32'h60; ramstate = FREE;
    cyc(); ramstate = ERROR; #2;
    total++; if (ctl !== 5'b10110) begin $display("FAIL rcv_e1: got %b want %b", ctl, 5'b10110); bad++; end
    cyc(); #2;
    total++; if (ctl !== 5'b10110) begin $display("FAIL rcv_e2: got %b want %b", ctl, 5'b10110); bad++; end
    cyc(); ramstate = ACCESS; ramload = 32'h77; #2;
    total++; if (ctl !== 5'b10010) begin $display("FAIL rcv_done: got %b want %b", ctl, 5'b10010); bad++; end
    total++; if (iload !== 32'h77) begin $display("FAIL rcv_iload: got %h want %h", iload, 32'h77); bad++; end
    cyc(); ramstate = FREE;
    cyc(); iaddr = 32'h64;
    cyc(); ramstate = ERROR; #2;
    total++; if (ctl !== 5'b10110) begin $display("FAIL rcv_cleared: got %b want %b", ctl, 5'b10110); bad++; end
    total++; if (ramaddr !== 32'h64) begin $display("FAIL rcv_addr2: got %h want %h", ramaddr, 32'h64); bad++; end
    cyc(); ramstate = ACCESS; #2;
    total++; if (ctl !== 5'b10010) begin $display("FAIL rcv_done2: got %b want %b", ctl, 5'b10010); bad++; end
    cyc(); iREN = 1'b0; ramstate = FREE;
    cyc();
  endtask

  task automatic test_reset_mid();
    cyc(); dWEN = 1'b1; daddr = 32'h200; dstore = 32'hBB; ramstate = FREE;
    cyc(); ramstate = BUSY; #2;
    total++; if (ctl !== 5'b01110) begin $display("FAIL rstm_pre: got %b want %b", ctl, 5'b01110); bad++; end
    #1 nRST = 1'b0;
    #1;
    total++; if (ctl !== 5'b00110) begin $display("FAIL rstm_async: got %b want %b", ctl, 5'b00110); bad++; end
    total++; if (ramaddr !== 32'h0) begin $display("FAIL rstm_addr: got %h want %h", ramaddr, 32'h0); bad++; end
    total++; if (ramstore !== 32'h0) begin $display("FAIL rstm_store: got %h want %h", ramstore, 32'h0); bad++; end
    dWEN = 1'b0; iREN = 1'b1; iaddr = 32'h300; ramstate = FREE;
    @(posedge CLK); #3 nRST = 1'b1;
    cyc(); #2;
    total++; if (ctl !== 5'b10110) begin $display("FAIL rstm_regrant: got %b want %b", ctl, 5'b10110); bad++; end
    total++; if (ramaddr !== 32'h300) begin $display("FAIL rstm_iaddr: got %h want %h", ramaddr, 32'h300); bad++; end
    cyc(); ramstate = ACCESS; #2;
    total++; if (ctl !== 5'b10010) begin $display("FAIL rstm_done: got %b want %b", ctl, 5'b10010); bad++; end
    cyc(); iREN = 1'b0; ramstate = FREE;
    cyc();
  endtask

`ifdef MEM_ARB_RR_EN
  task automatic test_rr();
    cyc(); iREN = 1'b1; iaddr = 32'h500; dWEN = 1'b1; daddr = 32'h600; dstore = 32'h9; ramstate = FREE;
    cyc(); ramstate = ACCESS; #2;
    total++; if (ctl !== 5'b01100) begin $display("FAIL rr_data_first: got %b want %b", ctl, 5'b01100); bad++; end
    cyc(); ramstate = FREE;
    cyc();
    cyc(); ramstate = ACCESS; #2;
    total++; if (ctl !== 5'b10010) begin $display("FAIL rr_inst_next: got %b want %b", ctl, 5'b10010); bad++; end
    total++; if (ramaddr !== 32'h500) begin $display("FAIL rr_iaddr: got %h want %h", ramaddr, 32'h500); bad++; end
    cyc(); iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_icache_read();
    test_priority();
    test_rw_both();
    test_withdraw();
    test_error_exhaust();
    test_error_recover();
    test_reset_mid();
`ifdef MEM_ARB_RR_EN
    test_rr();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
